// File: rtl/psum_drain_seq.sv
// psum_drain_seq: holds a 16-word partial-sum snapshot and steps the 16:1 output mux
// select through words 0..drain_len, one valid/ready beat per word.
module psum_drain_seq #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [DATA_W*NUM_WORDS-1:0] load_data,
    input  logic [3:0]                  drain_len,
    output logic [DATA_W-1:0]           buf_data_0,
    output logic [DATA_W-1:0]           buf_data_1,
    output logic [DATA_W-1:0]           buf_data_2,
    output logic [DATA_W-1:0]           buf_data_3,
    output logic [DATA_W-1:0]           buf_data_4,
    output logic [DATA_W-1:0]           buf_data_5,
    output logic [DATA_W-1:0]           buf_data_6,
    output logic [DATA_W-1:0]           buf_data_7,
    output logic [DATA_W-1:0]           buf_data_8,
    output logic [DATA_W-1:0]           buf_data_9,
    output logic [DATA_W-1:0]           buf_data_10,
    output logic [DATA_W-1:0]           buf_data_11,
    output logic [DATA_W-1:0]           buf_data_12,
    output logic [DATA_W-1:0]           buf_data_13,
    output logic [DATA_W-1:0]           buf_data_14,
    output logic [DATA_W-1:0]           buf_data_15,
    output logic [3:0]                  sel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        drain_done
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] hold_q [NUM_WORDS];
    logic [3:0]        len_q;
    logic              load_acc, beat, last_beat;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Handshake controls depend only on registered state; out_ready only gates the transition.
    always_comb begin
        state_nx   = state;
        load_ready = state == IDLE;
        out_valid  = state == DRAIN;
        out_last   = out_valid && sel == len_q;
        load_acc   = load_ready && load_valid;
        beat       = out_valid && out_ready;
        last_beat  = beat && out_last;
        if (load_acc)       state_nx = DRAIN;
        else if (last_beat) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) hold_q[i] <= '0;
            len_q      <= '0;
            sel        <= '0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= last_beat;
            if (load_acc) begin
                for (int i = 0; i < NUM_WORDS; i++) hold_q[i] <= load_data[DATA_W*i +: DATA_W];
                len_q <= drain_len;
                sel   <= '0;
            end else if (beat) begin
                sel <= out_last ? 4'd0 : sel + 4'd1;
            end
        end
    end

    assign buf_data_0  = hold_q[0];
    assign buf_data_1  = hold_q[1];
    assign buf_data_2  = hold_q[2];
    assign buf_data_3  = hold_q[3];
    assign buf_data_4  = hold_q[4];
    assign buf_data_5  = hold_q[5];
    assign buf_data_6  = hold_q[6];
    assign buf_data_7  = hold_q[7];
    assign buf_data_8  = hold_q[8];
    assign buf_data_9  = hold_q[9];
    assign buf_data_10 = hold_q[10];
    assign buf_data_11 = hold_q[11];
    assign buf_data_12 = hold_q[12];
    assign buf_data_13 = hold_q[13];
    assign buf_data_14 = hold_q[14];
    assign buf_data_15 = hold_q[15];
endmodule

// File: tb/tb_psum_drain_seq.sv
// tb_psum_drain_seq: directed and random drains checked against a queue-based word model.
module tb_psum_drain_seq;
    logic         clk = 0;
    logic         rst_n, load_valid, out_ready;
    logic [511:0] load_data;
    logic [3:0]   drain_len;
    logic         load_ready, out_valid, out_last, drain_done;
    logic [3:0]   sel;
    logic [31:0]  b [16];

    psum_drain_seq dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .drain_len(drain_len),
        .buf_data_0(b[0]), .buf_data_1(b[1]), .buf_data_2(b[2]), .buf_data_3(b[3]),
        .buf_data_4(b[4]), .buf_data_5(b[5]), .buf_data_6(b[6]), .buf_data_7(b[7]),
        .buf_data_8(b[8]), .buf_data_9(b[9]), .buf_data_10(b[10]), .buf_data_11(b[11]),
        .buf_data_12(b[12]), .buf_data_13(b[13]), .buf_data_14(b[14]), .buf_data_15(b[15]),
        .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    int           vectors = 0, miscompares = 0;
    logic [31:0]  pending [$];
    logic [511:0] snap = '0;
    int           total = 0;
    logic         exp_done = 0;
    logic         armed = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [511:0] all;
        int           n;
        for (int i = 0; i < 16; i++) all[32*i +: 32] = b[i];
        n = pending.size();
        chk("load_ready", load_ready, n == 0);
        chk("out_valid", out_valid, n != 0);
        chk("out_last", out_last, n == 1);
        chk("sel", sel, n ? total - n : 0);
        chk("drain_done", drain_done, exp_done);
        chk("buf_data", all, snap);
        if (n != 0) chk("mux_word", all[32*sel +: 32], pending[0]);
    endtask

    task automatic step(input logic rn, input logic lv, input logic [511:0] ld,
                        input logic [3:0] dl, input logic rdy);
        @(negedge clk);
        if (armed) check_outputs();
        rst_n = rn; load_valid = lv; load_data = ld; drain_len = dl; out_ready = rdy;
        exp_done = 0;
        if (!rn) begin
            pending.delete();
            snap = '0;
        end else if (pending.size() == 0) begin
            if (lv) begin
                snap  = ld;
                total = dl + 1;
                for (int i = 0; i <= dl; i++) pending.push_back(ld[32*i +: 32]);
            end
        end else if (rdy) begin
            void'(pending.pop_front());
            exp_done = pending.size() == 0;
        end
    endtask

    function automatic logic [511:0] rand_snap();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [511:0] ramp, other, d;
        logic [3:0]   rp [7] = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 16; i++) ramp[32*i +: 32] = i;
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        armed = 1;
        step(1, 0, '0, 0, 0);
        // basic full drain
        step(1, 1, ramp, 15, 1);
        for (int i = 0; i < 18; i++) step(1, 0, '0, 0, 1);
        // back-pressure
        step(1, 1, ~ramp, 3, 0);
        for (int i = 0; i < 7; i++) step(1, 0, '0, 0, rp[i][0]);
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
        // short drain
        d = rand_snap();
        d[31:0] = 32'hDEADBEEF;
        step(1, 1, d, 0, 1);
        step(1, 0, '0, 0, 1);
        step(1, 0, '0, 0, 1);
        // load ignored while busy
        d = rand_snap();
        other = rand_snap();
        step(1, 1, d, 9, 1);
        step(1, 0, '0, 0, 1);
        step(1, 1, other, 2, 0);
        step(1, 1, other, 2, 1);
        for (int i = 0; i < 10; i++) step(1, 0, '0, 0, 1);
        // reset mid-drain at sel=7
        step(1, 1, rand_snap(), 15, 1);
        for (int i = 0; i < 7; i++) step(1, 0, '0, 0, 1);
        step(0, 0, '0, 0, 1);
        step(1, 0, '0, 0, 1);
        step(1, 1, rand_snap(), 4, 1);
        for (int i = 0; i < 7; i++) step(1, 0, '0, 0, 1);
        // back-to-back snapshots
        step(1, 1, rand_snap(), 1, 1);
        step(1, 1, rand_snap(), 1, 1);
        step(1, 1, rand_snap(), 1, 1);
        step(1, 1, rand_snap(), 1, 1);
        step(1, 1, rand_snap(), 1, 1);
        step(1, 0, '0, 0, 1);
        step(1, 0, '0, 0, 1);
        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0, rand_snap(),
                 4'($urandom), $urandom_range(0, 3) != 0);
        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/psum_drain_seq.md
# psum_drain_seq

Sequencer and holding buffer that sits directly upstream of the 16:1 32-bit output mux in the accumulator read-out path. It captures a 16-word partial-sum snapshot from the PE array in one cycle. It presents the 16 held words to the mux data inputs and steps the 4-bit mux select through them. Each selected word is qualified with a valid/ready handshake toward the downstream consumer, and the consumer reads the mux output.

## Interface
Parameters:
- DATA_W, 32, width of each buffered word; the downstream mux is 32-bit, so only 32 is supported
- NUM_WORDS, 16, buffer depth; fixed to match the 4-bit select

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low (sampled only on rising clk)
- load_valid  in  1  snapshot offered by the PE array
- load_ready  out  1  block can accept a snapshot
- load_data  in  512  16 words, word i at bits [32*i+31 : 32*i]
- drain_len  in  4  index of the last word to drain (words 0..drain_len); sampled with the load
- buf_data_0 … buf_data_15  out  32 each  held words, wired to mux inputs 0..15
- sel  out  4  mux select; index of the word currently offered
- out_valid  out  1  mux output currently holds a valid word
- out_ready  in  1  consumer accepts the word this cycle
- out_last  out  1  current word is the final word of the snapshot
- drain_done  out  1  one-cycle pulse after the final word is accepted

## Operation
- FSM states: IDLE, DRAIN.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid=1, the block does all of the following at the same edge:
    - captures all 16 words into buf_data_0..15;
    - captures drain_len into len_q;
    - sets sel to 0;
    - moves to DRAIN.
- DRAIN:
  - load_ready=0; load_valid is ignored and the buffer does not change.
  - out_valid=1.
  - out_last=1 when sel==len_q.
- Beat acceptance: a handshake is out_valid & out_ready.
  - If sel!=len_q: sel increments by 1.
  - If sel==len_q: sel returns to 0, the FSM returns to IDLE, and drain_done pulses high on the next cycle.
- out_ready=0 in DRAIN: sel, buf_data_*, out_valid and out_last all hold.
- drain_len=0: exactly one beat, word 0, with out_last=1 on that beat.
- drain_len=15: all 16 words. sel reaches 15 and never wraps to 0 while in DRAIN.
- In IDLE, buf_data_* keep their last captured values. They are not cleared after a drain.
- sel arithmetic is 4-bit unsigned. Overflow is impossible because the drain terminates at len_q ≤ 15.
- Reset (rst_n=0 at a rising edge), whether idle or mid-drain, gives:
  - state=IDLE;
  - sel=0, len_q=0;
  - all buf_data_*=0;
  - out_valid=0, out_last=0, drain_done=0;
  - load_ready=1 from the first cycle after reset is released.
  - Any partial drain is discarded with no drain_done.

## Timing
- Load accepted at edge N: out_valid=1 and sel=0 from cycle N+1.
- With out_ready held at 1: one word per cycle, so a drain of drain_len+1 words takes drain_len+1 cycles.
  - The final handshake at edge M gives drain_done=1 and load_ready=1 during cycle M+1.
  - The earliest next load is accepted at edge M+1.
- Data path latency:
  - buf_data_* and sel are registered outputs.
  - Mux output is valid in the same cycle that sel is presented; no extra pipeline stage.
- out_valid, out_last and load_ready are decoded from registered state only; no combinational path from out_ready or load_valid.
- drain_done is registered, exactly one cycle wide.

## Test plan
- Reset then basic drain:
  - Stimulus: load words 0x00000000..0x0000000F (word i = i), drain_len=15, out_ready=1.
  - Required response: sel 0..15 on 16 consecutive cycles starting the cycle after the load; mux output equals i at sel=i; out_last only at sel=15; drain_done one cycle later.
- Back-pressure:
  - Stimulus: drain_len=3; out_ready pattern 1,0,0,1,1,0,1.
  - Required response: sel sequence 0,1,1,1,2,3,3 then IDLE; accepted words 0,1,2,3 in order; no skipped or repeated words.
- Short drain:
  - Stimulus: drain_len=0, load word0=0xDEADBEEF.
  - Required response: a single beat with sel=0, output 0xDEADBEEF, out_last=1; drain_done next cycle.
- Load ignored while busy:
  - Stimulus: pulse load_valid with new data mid-drain.
  - Required response: load_ready=0 during the drain; buf_data_* unchanged; remaining words come from the original snapshot.
- Reset mid-drain:
  - Stimulus: drain_len=15; assert rst_n=0 at sel=7 for one edge.
  - Required response: next cycle out_valid=0, sel=0, buf_data_*=0, no drain_done; a subsequent load drains normally from sel=0.
- Back-to-back snapshots:
  - Stimulus: load_valid held at 1 with two different snapshots, drain_len=1, out_ready=1.
  - Required response: second load accepted exactly one cycle after the last beat of the first; sel pattern 0,1,(idle),0,1.
